muxn_rr_reg: RTL and testbench

- Parametrised successor of the 2:1 mux: NUM_IN channels of DATA_W bits are merged onto one output with valid/ready handshakes.
- Two selection modes: fixed select (a steered mux) and round-robin arbitration.
- The output is registered, giving one-cycle latency and full throughput.
- Sits between multiple producer streams and a single consumer, for example a shared bus or a FIFO write port.

---
 rtl/mux_pkg.sv | 14 +
 rtl/rr_arbiter_n.sv | 34 +++
 rtl/muxn_rr_reg.sv | 100 ++++++++++
 tb/tb_muxn_rr_reg.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin / fixed-select stream mux.
package mux_pkg;

    // Selection modes presented on the mode input
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for n channels; never below one bit so a 1- or 2-channel
    // build still has a usable select/grant index.
    function automatic int clog2Min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: picks the first requester after ptr,
// wrapping modulo NUM_IN, and reports it as one-hot plus an index.
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = clog2Min1(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_IN-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any_gnt
);

    logic [SEL_W-1:0] cand;

    // Walk ptr+1, ptr+2, ... ptr+NUM_IN (the last one is ptr itself) and keep the first hit
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand    = '0;
        for (int off = 1; off <= NUM_IN; off++) begin
            cand = SEL_W'((int'(ptr) + off) % NUM_IN);
            if (!any_gnt && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                any_gnt   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/muxn_rr_reg.sv
// NUM_IN-to-1 stream mux with valid/ready handshakes, fixed or round-robin
// selection, and a registered output stage (1-cycle latency, full throughput).
module muxn_rr_reg
    import mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = clog2Min1(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_idx,
    input  logic                     out_ready
);

    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic              outValid_q, outValid_d;
    logic [DATA_W-1:0] outData_q, outData_d;
    logic [SEL_W-1:0]  outIdx_q, outIdx_d;

    logic              load;
    logic [NUM_IN-1:0] fixedGnt, rrGnt, grant;
    logic [SEL_W-1:0]  rrIdx, grantIdx;
    logic              fixedAny, rrAny, anyGrant;

    rr_arbiter_n #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) uArb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (rrGnt),
        .gnt_idx (rrIdx),
        .any_gnt (rrAny)
    );

    // Fixed steering: only the selected channel can win, and an out-of-range select wins nothing
    always_comb begin
        fixedGnt = '0;
        fixedAny = 1'b0;
        if (int'(sel) < NUM_IN) begin
            fixedGnt[sel] = in_valid[sel];
            fixedAny      = in_valid[sel];
        end
    end

    // Pick the active grant source and gate readiness with the output register's ability to load
    always_comb begin
        grant    = (mode == MODE_FIXED) ? fixedGnt : rrGnt;
        grantIdx = (mode == MODE_FIXED) ? sel      : rrIdx;
        anyGrant = (mode == MODE_FIXED) ? fixedAny : rrAny;
        load     = ~outValid_q | out_ready;
        in_ready = (load && rst_n) ? grant : '0;
    end

    // Next state of the output register and the round-robin pointer
    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outIdx_d   = outIdx_q;
        ptr_d      = ptr_q;
        if (load) begin
            outValid_d = anyGrant;
            if (anyGrant) begin
                outData_d = in_data[int'(grantIdx)*DATA_W +: DATA_W];
                outIdx_d  = grantIdx;
                if (mode == MODE_RR) begin
                    ptr_d = grantIdx;
                end
            end
        end
    end

    // State registers; ptr resets to the last channel so channel 0 is served first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outIdx_q   <= '0;
            ptr_q      <= SEL_W'(NUM_IN - 1);
        end else begin
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outIdx_q   <= outIdx_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_idx   = outIdx_q;

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Scoreboard bench for muxn_rr_reg: a 4-channel build carries the main
// directed sequence, a 5-channel build covers the out-of-range select.
module tb_muxn_rr_reg;
    import mux_pkg::*;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } beat_t;

    logic        clk;
    logic        rst_n;

    // 4-channel instance
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_ready;

    // 5-channel instance
    logic        mode5;
    logic [2:0]  sel5;
    logic [4:0]  inValid5;
    logic [39:0] inData5;
    logic [4:0]  inReady5;
    logic        outValid5;
    logic [7:0]  outData5;
    logic [2:0]  outIdx5;
    logic        outReady5;

    int          testsRun;
    int          failures;
    logic        expOutValid;
    beat_t       expQ[$];
    beat_t       monBeat;

    muxn_rr_reg #(.NUM_IN(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_ready (out_ready)
    );

    muxn_rr_reg #(.NUM_IN(5), .DATA_W(8)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode5),
        .sel       (sel5),
        .in_valid  (inValid5),
        .in_data   (inData5),
        .in_ready  (inReady5),
        .out_valid (outValid5),
        .out_data  (outData5),
        .out_idx   (outIdx5),
        .out_ready (outReady5)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value against its expectation and tally the result
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs (called just after a rising edge), check ready and
    // valid mid-cycle, and queue the beat the hand-computed ready implies
    task automatic applyStimulus(input string name, input logic m, input logic [1:0] s,
                                 input logic [3:0] v, input logic ordy,
                                 input logic [3:0] expReady, input logic chkHold);
        beat_t b;
        b = '0;
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = ordy;
        @(negedge clk);
        checkOutput({name, " out_valid"}, 32'(out_valid), 32'(expOutValid));
        checkOutput({name, " in_ready"}, 32'(in_ready), 32'(expReady));
        if (chkHold) begin
            checkOutput({name, " held out_data"}, 32'(out_data), 32'h11);
            checkOutput({name, " held out_idx"}, 32'(out_idx), 32'd1);
        end
        if (expReady != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (expReady[i]) begin
                    b.idx  = 2'(i);
                    b.data = 8'(8'h11 * i);
                end
            end
            expQ.push_back(b);
        end
        if (!expOutValid || ordy) begin
            expOutValid = (expReady != 4'b0000);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every beat the consumer takes must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                testsRun++;
                failures++;
                $display("[TB] FAIL unexpected beat: got idx %0d data 0x%0h, expected none", out_idx, out_data);
            end else begin
                monBeat = expQ.pop_front();
                checkOutput("beat idx", 32'(out_idx), 32'(monBeat.idx));
                checkOutput("beat data", 32'(out_data), 32'(monBeat.data));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence with hand-computed grants
    initial begin
        testsRun    = 0;
        failures    = 0;
        expOutValid = 1'b0;
        in_data     = {8'h33, 8'h22, 8'h11, 8'h00};
        inData5     = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
        mode        = MODE_RR;
        sel         = 2'd0;
        in_valid    = 4'b1111;
        out_ready   = 1'b1;
        mode5       = MODE_FIXED;
        sel5        = 3'd0;
        inValid5    = 5'b00000;
        outReady5   = 1'b1;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;

        // Reset held with every channel valid: nothing may be accepted
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset out_valid", 32'(out_valid), 32'd0);
            checkOutput("reset out_data", 32'(out_data), 32'h00);
            checkOutput("reset in_ready", 32'(in_ready), 32'b0000);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin with all valid: 0,1,2,3,0,1,2,3
        applyStimulus("rr0", MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0);
        applyStimulus("rr1", MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b0);
        applyStimulus("rr2", MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b0);
        applyStimulus("rr3", MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b0);
        applyStimulus("rr4", MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0);
        applyStimulus("rr5", MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b0);
        applyStimulus("rr6", MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b0);
        applyStimulus("rr7", MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b0);

        // Only channels 1 and 3 valid: alternate 1,3,1,3
        applyStimulus("rrA", MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b0);
        applyStimulus("rrB", MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b0);
        applyStimulus("rrC", MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b0);
        applyStimulus("rrD", MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b0);

        // Fixed select on channel 2, then channel 3
        applyStimulus("fix2a", MODE_FIXED, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b0);
        applyStimulus("fix2b", MODE_FIXED, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b0);
        applyStimulus("fix2c", MODE_FIXED, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b0);
        applyStimulus("fix3", MODE_FIXED, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b0);

        // Backpressure: load 0x11, stall five cycles, then accept with no bubble
        applyStimulus("bp load", MODE_FIXED, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("bp stall", MODE_FIXED, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1);
        end
        applyStimulus("bp resume", MODE_FIXED, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b0);

        // Mode switch: round-robin pointer survives a stint in fixed mode
        applyStimulus("ms rr0", MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0);
        applyStimulus("ms rr2", MODE_RR, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b0);
        applyStimulus("ms fix0a", MODE_FIXED, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0);
        applyStimulus("ms fix0b", MODE_FIXED, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0);
        applyStimulus("ms fix0c", MODE_FIXED, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0);
        applyStimulus("ms rr3", MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b0);
        applyStimulus("ms rr0b", MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0);

        // Idle: output drains and out_valid falls
        applyStimulus("idle1", MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0);
        applyStimulus("idle2", MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0);

        // Asynchronous reset while a beat is pending
        applyStimulus("ar load", MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b0);
        applyStimulus("ar stall", MODE_RR, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
        expQ.delete();
        expOutValid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus("ar first", MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0);
        applyStimulus("ar idle1", MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0);
        applyStimulus("ar idle2", MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0);

        // Five-channel build: select 4 works, select 7 grants nothing
        mode5    = MODE_FIXED;
        sel5     = 3'd4;
        inValid5 = 5'b11111;
        @(negedge clk);
        checkOutput("n5 sel4 in_ready", 32'(inReady5), 32'b10000);
        @(posedge clk);
        #1 sel5 = 3'd7;
        @(negedge clk);
        checkOutput("n5 sel4 out_valid", 32'(outValid5), 32'd1);
        checkOutput("n5 sel4 out_idx", 32'(outIdx5), 32'd4);
        checkOutput("n5 sel4 out_data", 32'(outData5), 32'hA4);
        checkOutput("n5 sel7 in_ready", 32'(inReady5), 32'b00000);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("n5 sel7 out_valid", 32'(outValid5), 32'd0);
        checkOutput("n5 sel7 out_data hold", 32'(outData5), 32'hA4);

        // Every queued beat must have been consumed
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
